uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_sched_if.sv | 26 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_sched.sv | 124 ++++++++++++
 tb/tb_uart_tx_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM state codes and tag marker.
package uart_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_TAG_ENC  = 2'd1;
  localparam logic [1:0] ST_SEND_ENC = 2'd2;
  localparam logic [1:0] ST_WAIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_TAG  = ST_TAG_ENC,
    S_SEND = ST_SEND_ENC,
    S_WAIT = ST_WAIT_ENC
  } sched_state_t;

  // MSB of a tag character; distinguishes it from payload on the wire.
  localparam logic TAG_MSB_MARK = 1'b1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter handshake bundle for uart_tx_sched.
// master = requesters + transmitter side, slave = the scheduler.
interface uart_tx_sched_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;

  modport master (
    output req_valid, req_data, req_last, tx_done_tick,
    input  req_ready, tx_start, tx_din
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_done_tick,
    output req_ready, tx_start, tx_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  // Scan farthest-to-nearest so the nearest request overwrites any earlier hit.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Define UART_SCHED_TAG_EN to prefix every grant with a requester tag character.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters
// TAG   | send {1, 0.., grant_id} tag character (UART_SCHED_TAG_EN only)
// SEND  | accept one character from the granted requester, or release
// WAIT  | wait for tx_done_tick, then continue burst or release
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DBIT      = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = $clog2(NREQ),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_sched_if.slave bus,
  output logic [IW-1:0] grant_id,
  output logic          busy
);

  sched_state_t    state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] arb_gnt;
  logic [BW-1:0]   burst_cnt;
  logic            last_q;
  logic            accept;
  logic            start_c;
  logic [DBIT-1:0] din_q;
  logic [DBIT-1:0] din_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign accept   = (state == S_SEND) && bus.req_valid[grant_id];
  assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
  assign busy     = (state != S_IDLE);

  // Accept strobe and character are combinational so the transfer lands in the SEND cycle.
  always_comb begin
    start_c       = 1'b0;
    din_c         = din_q;
    bus.req_ready = '0;
    if (accept) begin
      start_c                 = 1'b1;
      din_c                   = bus.req_data[grant_id*DBIT +: DBIT];
      bus.req_ready[grant_id] = 1'b1;
    end
`ifdef UART_SCHED_TAG_EN
    else if (state == S_TAG) begin
      start_c          = 1'b1;
      din_c            = '0;
      din_c[DBIT-1]    = TAG_MSB_MARK;
      din_c[IW-1:0]    = grant_id;
    end
`endif
  end

  assign bus.tx_start = start_c;
  assign bus.tx_din   = din_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      last_q    <= 1'b0;
      din_q     <= '0;
    end else begin
      if (start_c) din_q <= din_c;
      case (state)
        S_IDLE: begin
          if (|arb_gnt) begin
            grant_id  <= arb_idx;
            burst_cnt <= '0;
`ifdef UART_SCHED_TAG_EN
            state     <= S_TAG;
`else
            state     <= S_SEND;
`endif
          end
        end
`ifdef UART_SCHED_TAG_EN
        S_TAG: begin
          last_q <= 1'b0;
          state  <= S_WAIT;
        end
`endif
        S_SEND: begin
          if (bus.req_valid[grant_id]) begin
            last_q <= bus.req_last[grant_id];
            if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
            state  <= S_WAIT;
          end else begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.tx_done_tick) begin
            if (last_q || (burst_cnt == BW'(MAX_BURST))) begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end else begin
              state  <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_sched;

  logic       clk;
  logic       reset_n;
  logic [1:0] gid;
  logic       busy;

  uart_tx_sched_if #(.NREQ(4), .DBIT(8)) bus ();

  uart_tx_sched #(.NREQ(4), .DBIT(8), .MAX_BURST(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (gid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Table-phase drive and environment-phase drive are muxed onto the bus.
  logic        env_on    = 1'b0;
  logic        env_clr   = 1'b0;
  logic [3:0]  tbl_valid = 4'b0;
  logic        tbl_done  = 1'b0;
  logic [3:0]  env_valid = 4'b0;
  logic [3:0]  env_last  = 4'b0;
  logic [31:0] env_data  = 32'h0;
  logic        done_env  = 1'b0;

  assign bus.req_valid    = env_on ? env_valid : tbl_valid;
  assign bus.req_data     = env_on ? env_data  : 32'h3320_5510;
  assign bus.req_last     = env_on ? env_last  : 4'b0111;
  assign bus.tx_done_tick = env_on ? done_env  : tbl_done;

  // Requester and transmitter models
  int         rq_sent  [4] = '{0, 0, 0, 0};
  int         rq_total [4] = '{0, 0, 0, 0};
  logic [7:0] rq_base  [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       rq_nolast[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] samp_acc   = 4'b0;
  logic       samp_start = 1'b0;
  int         tcnt       = 0;

  always @(negedge clk) begin
    samp_acc   = bus.req_valid & bus.req_ready;
    samp_start = bus.tx_start;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (env_clr) rq_sent[i] = 0;
      else if (env_on && samp_acc[i]) rq_sent[i]++;
      env_valid[i]        = env_on && (rq_sent[i] < rq_total[i]);
      env_data[i*8 +: 8]  = rq_base[i] + 8'(rq_sent[i]);
      env_last[i]         = !rq_nolast[i] && (rq_sent[i] == rq_total[i] - 1);
    end
    // done returns 10 cycles after the start cycle
    if (samp_start) tcnt = 10;
    else if (tcnt > 0) tcnt--;
    done_env = env_on && (tcnt == 1);
  end

  // Start-pulse log and back-to-back detector
  logic [7:0] log_din[256];
  logic [1:0] log_gid[256];
  logic       log_rdy[256];
  int         log_n      = 0;
  int         mon_b2b    = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      if (log_n < 256) begin
        log_din[log_n] = bus.tx_din;
        log_gid[log_n] = gid;
        log_rdy[log_n] = |bus.req_ready;
      end
      log_n++;
      if (prev_start) mon_b2b++;
    end
    prev_start = (bus.tx_start === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    env_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    env_clr = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (log_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(log_n >= n), 32'd1);
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int c;
    c = 0;
    while (!(busy === 1'b0 && env_valid === 4'b0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 32'(busy === 1'b0), 32'd1);
  endtask

  typedef struct packed {
    logic [3:0] valid;
    logic       done;
    logic [3:0] rdy;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int s;
    int r;
    int j;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    // outputs under reset, before release
    chk("rst.tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.tx_din", 32'(bus.tx_din), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.grant_id", 32'(gid), 32'd0);
    reset_n = 1'b1;

`ifndef UART_SCHED_TAG_EN
    //             valid    done  rdy      start din    busy gid
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[3]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'h55, 1'b1, 2'd1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h55, 1'b1, 2'd1};
    tbl[6]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd1};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 8'h20, 1'b1, 2'd2};
    tbl[8]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'h20, 1'b1, 2'd2};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h20, 1'b0, 2'd2};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h20, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h20, 1'b0, 2'd0};
    tbl[12] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 8'h20, 1'b0, 2'd0};
    tbl[13] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd3};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd3};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd3};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b0, 2'd3};

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      tbl_valid = tbl[i].valid;
      tbl_done  = tbl[i].done;
      @(negedge clk);
      chk($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d.tx_start", i), 32'(bus.tx_start), 32'(tbl[i].start));
      chk($sformatf("v%0d.tx_din", i), 32'(bus.tx_din), 32'(tbl[i].din));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d.grant_id", i), 32'(gid), 32'(tbl[i].gid));
    end
    @(posedge clk);
    #1;
    tbl_valid = 4'b0;
    tbl_done  = 1'b0;
    repeat (15) @(negedge clk);

    // Requester 2 alone: three-character message
    do_reset();
    env_on      = 1'b1;
    rq_base[2]  = 8'h41;
    rq_total[2] = 3;
    b = log_n;
    wait_log(b + 3, 150, "msg3.starts_seen");
    wait_quiet(100, "msg3.idle_after");
    repeat (5) @(negedge clk);
    chk("msg3.start_count", 32'(log_n - b), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("msg3.din%0d", k), 32'(log_din[b+k]), 32'h41 + 32'(k));
      chk($sformatf("msg3.gid%0d", k), 32'(log_gid[b+k]), 32'd2);
      chk($sformatf("msg3.ready%0d", k), 32'(log_rdy[b+k]), 32'd1);
    end
    chk("msg3.busy", 32'(busy), 32'd0);
    chk("msg3.grant_id", 32'(gid), 32'd2);
    rq_total[2] = 0;

    // All four requesters continuously valid, never last: bursts of MAX_BURST
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq_base[i]   = 8'(i * 16);
      rq_total[i]  = 1000;
      rq_nolast[i] = 1'b1;
    end
    b = log_n;
    wait_log(b + 20, 800, "rr.starts_seen");
    for (int k = 0; k < 20; k++) begin
      r = (k / 4) % 4;
      j = (k / 16) * 4 + (k % 4);
      chk($sformatf("rr.gid%0d", k), 32'(log_gid[b+k]), 32'(r));
      chk($sformatf("rr.din%0d", k), 32'(log_din[b+k]), 32'(r * 16 + j));
    end
    for (int i = 0; i < 4; i++) rq_total[i] = 0;
    wait_quiet(200, "rr.idle_after");

    // Reset pulse while in WAIT
    do_reset();
    rq_base[1]  = 8'h60;
    rq_total[1] = 100;
    b = log_n;
    wait_log(b + 1, 50, "rstw.start_seen");
    @(posedge clk);
    #3;
    chk("rstw.busy_in_wait", 32'(busy), 32'd1);
    chk("rstw.gid_in_wait", 32'(gid), 32'd1);
    reset_n     = 1'b0;
    rq_total[1] = 0;
    #1;
    chk("rstw.tx_start", 32'(bus.tx_start), 32'd0);
    chk("rstw.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rstw.tx_din", 32'(bus.tx_din), 32'd0);
    chk("rstw.busy", 32'(busy), 32'd0);
    chk("rstw.grant_id", 32'(gid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s = log_n;
    repeat (15) @(negedge clk);
    chk("rstw.stale_done_no_start", 32'(log_n - s), 32'd0);
    chk("rstw.stale_done_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) rq_nolast[i] = 1'b0;
    rq_base[0]  = 8'h70;
    rq_total[0] = rq_sent[0] + 1;
    rq_total[1] = rq_sent[1] + 1;
    b = log_n;
    wait_log(b + 2, 100, "rstw.restart_seen");
    chk("rstw.first_gid", 32'(log_gid[b]), 32'd0);
    chk("rstw.first_din", 32'(log_din[b]), 32'h70);
    chk("rstw.second_gid", 32'(log_gid[b+1]), 32'd1);
    wait_quiet(100, "rstw.idle_after");
`else
    // Tag prefix for requester 3
    do_reset();
    env_on      = 1'b1;
    rq_base[3]  = 8'h5A;
    rq_total[3] = 1;
    b = log_n;
    wait_log(b + 2, 100, "tag.starts_seen");
    chk("tag.tag_din", 32'(log_din[b]), 32'h83);
    chk("tag.tag_ready", 32'(log_rdy[b]), 32'd0);
    chk("tag.tag_gid", 32'(log_gid[b]), 32'd3);
    chk("tag.payload_din", 32'(log_din[b+1]), 32'h5A);
    chk("tag.payload_ready", 32'(log_rdy[b+1]), 32'd1);
    wait_quiet(100, "tag.idle_after");
    repeat (5) @(negedge clk);
    chk("tag.start_count", 32'(log_n - b), 32'd2);
`endif

    chk("no_back_to_back_start", 32'(mon_b2b), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
